// File: rtl/lsu_pkg.sv
// Shared LSU types for the store-AGU TLB-miss scheduler.
//   msched_state_t : scheduler FSM encoding
//   miss_entry_t   : one queued miss {addr, attr, thread} at the default address width
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W  = 44;
  localparam int unsigned MISS_ATTR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    HOLD   = 2'd2,
    REPLAY = 2'd3
  } msched_state_t;

  typedef struct packed {
    logic [LSU_ADDR_W-1:0]  addr;
    logic [MISS_ATTR_W-1:0] attr;
    logic                   thread;
  } miss_entry_t;

endpackage

// File: rtl/miss_fifo.sv
// Circular miss queue.
//   push/pop/flush : enqueue din, dequeue head, discard everything (flush wins)
//   head           : oldest entry
//   count          : occupancy, clog2(DEPTH)+1 bits
//   full           : count == DEPTH
module miss_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 49
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  // A full queue refuses pushes even when a pop happens in the same cycle.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (count_q != '0);
  assign head    = mem[rd_q];
  assign count   = count_q;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_q] <= din;
        wr_q      <= PTR_W'(wr_q + PTR_W'(1));
      end
      if (pop_ok) rd_q <= PTR_W'(rd_q + PTR_W'(1));
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sagu_miss_sched.sv
// Store-AGU TLB-miss scheduler: queues tlbMiss ops, walks the head in order,
// then replays it into sagu through the mex side port while holding the bus.
//   miss_*          : missing op capture
//   walk_*          : page-walk handshake for the head entry
//   bus_hold, mex_* : replay slot and replayed op
//   fault_*         : head dropped after a faulting walk
//   full, overflow  : queue full (combinational), sticky drop-while-full flag
module sagu_miss_sched
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              except,
  input  logic              miss_en,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [3:0]        miss_attr,
  input  logic              miss_thread,
  output logic              walk_req,
  output logic [ADDR_W-1:0] walk_addr,
  output logic              walk_thread,
  input  logic              walk_ack,
  input  logic              walk_fault,
  output logic              bus_hold,
  output logic              mex_en,
  output logic [ADDR_W-1:0] mex_addr,
  output logic [3:0]        mex_attr,
  output logic              fault_en,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned ENT_W = ADDR_W + MISS_ATTR_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  msched_state_t    state_q, state_d;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             walk_req_d;
  logic             bus_hold_d;
  logic             mex_en_d;
  logic             fault_en_d;
  logic             overflow_d;

  // Head leaves the queue in the REPLAY cycle, or one cycle after a faulting ack
  // so fault_addr still shows it while fault_en is high.
  assign push      = miss_en & ~except & ~full;
  assign pop       = (state_q == REPLAY) | fault_en;
  assign push_data = {miss_addr, miss_attr, miss_thread};

  miss_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (except),
    .din   (push_data),
    .head  (head),
    .count (count),
    .full  (full)
  );

  // Head fields feed every data output.
  assign walk_addr   = head[ENT_W-1 -: ADDR_W];
  assign walk_thread = head[0];
  assign mex_addr    = head[ENT_W-1 -: ADDR_W];
  assign mex_attr    = head[MISS_ATTR_W:1];
  assign fault_addr  = head[ENT_W-1 -: ADDR_W];

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      walk_req <= 1'b0;
      bus_hold <= 1'b0;
      mex_en   <= 1'b0;
      fault_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      walk_req <= walk_req_d;
      bus_hold <= bus_hold_d;
      mex_en   <= mex_en_d;
      fault_en <= fault_en_d;
      overflow <= overflow_d;
    end
  end

  // Next state and next registered outputs; except overrides everything.
  always_comb begin
    state_d    = state_q;
    fault_en_d = 1'b0;
    overflow_d = overflow | (miss_en & full);
    if (except) begin
      state_d    = IDLE;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        // Ignore the entry being popped by a fault this cycle.
        IDLE:    if (count > CNT_W'(pop)) state_d = WALK;
        WALK: begin
          if (walk_ack) begin
            if (walk_fault) begin
              fault_en_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD:    state_d = REPLAY;
        REPLAY:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    walk_req_d = (state_d == WALK);
    bus_hold_d = (state_d == HOLD) | (state_d == REPLAY);
    mex_en_d   = (state_d == REPLAY);
  end

endmodule

// File: tb/tb_sagu_miss_sched.sv
// Bench for sagu_miss_sched: directed timing scenarios, then random traffic
// checked against a queue-level reference model.
module tb_sagu_miss_sched;
  import lsu_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 44;

  logic              clk;
  logic              rst;
  logic              except;
  logic              miss_en;
  logic [ADDR_W-1:0] miss_addr;
  logic [3:0]        miss_attr;
  logic              miss_thread;
  logic              walk_req;
  logic [ADDR_W-1:0] walk_addr;
  logic              walk_thread;
  logic              walk_ack;
  logic              walk_fault;
  logic              bus_hold;
  logic              mex_en;
  logic [ADDR_W-1:0] mex_addr;
  logic [3:0]        mex_attr;
  logic              fault_en;
  logic [ADDR_W-1:0] fault_addr;
  logic              full;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  miss_entry_t expq[$];
  miss_entry_t mq[$];

  sagu_miss_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .except      (except),
    .miss_en     (miss_en),
    .miss_addr   (miss_addr),
    .miss_attr   (miss_attr),
    .miss_thread (miss_thread),
    .walk_req    (walk_req),
    .walk_addr   (walk_addr),
    .walk_thread (walk_thread),
    .walk_ack    (walk_ack),
    .walk_fault  (walk_fault),
    .bus_hold    (bus_hold),
    .mex_en      (mex_en),
    .mex_addr    (mex_addr),
    .mex_attr    (mex_attr),
    .fault_en    (fault_en),
    .fault_addr  (fault_addr),
    .full        (full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic miss_entry_t mk(input logic [43:0] a, input logic [3:0] at, input logic th);
    miss_entry_t e;
    e.addr = a; e.attr = at; e.thread = th;
    return e;
  endfunction

  function automatic miss_entry_t rnd_ent();
    return mk(44'({$urandom(), $urandom()}), 4'($urandom()), 1'($urandom()));
  endfunction

  task automatic push_miss(input miss_entry_t e);
    miss_en = 1'b1; miss_addr = e.addr; miss_attr = e.attr; miss_thread = e.thread;
    nxt();
    miss_en = 1'b0;
  endtask

  task automatic wait_walk();
    int n = 0;
    while (walk_req !== 1'b1 && n < 50) begin nxt(); n++; end
    chk("walk_req_wait", walk_req, 1'b1);
  endtask

  // Ack every walk without fault; replays must match expq in order.
  task automatic drain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      if (mex_en === 1'b1) begin
        chk("replay_addr", mex_addr, expq[0].addr);
        chk("replay_attr", mex_attr, expq[0].attr);
        void'(expq.pop_front());
      end
      walk_ack = walk_req; walk_fault = 1'b0;
      nxt(); n++;
    end
    walk_ack = 1'b0;
    chk("drain_done", 64'(expq.size()), 0);
  endtask

  miss_entry_t e1, e2, ea, eb, ec;
  miss_entry_t f[5];
  logic [1:0]  sch_hold, sch_mex, sch_fault;
  logic        ovf;
  logic        quiesce;
  logic        push_ok;

  initial begin
    rst = 1'b1; except = 1'b0; miss_en = 1'b0; miss_addr = '0; miss_attr = '0;
    miss_thread = 1'b0; walk_ack = 1'b0; walk_fault = 1'b0;
    nxt(); nxt();
    // Reset state
    chk("rst_walk_req", walk_req, 0);
    chk("rst_bus_hold", bus_hold, 0);
    chk("rst_mex_en", mex_en, 0);
    chk("rst_fault_en", fault_en, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", dut.count, 0);
    rst = 1'b0;
    nxt();

    // Single miss: walk_req at T+2, ack at T+5, hold T+6..T+7, replay T+7
    e1 = mk(44'h0123456780, 4'h5, 1'b1);
    push_miss(e1);
    chk("s_count_t1", dut.count, 1);
    chk("s_walk_req_t1", walk_req, 0);
    nxt();
    chk("s_walk_req_t2", walk_req, 1);
    chk("s_walk_addr", walk_addr, e1.addr);
    chk("s_walk_thread", walk_thread, 1);
    nxt(); nxt(); nxt();
    walk_ack = 1'b1;
    nxt();
    walk_ack = 1'b0;
    chk("s_walk_req_a1", walk_req, 0);
    chk("s_hold_a1", bus_hold, 1);
    chk("s_mex_a1", mex_en, 0);
    nxt();
    chk("s_hold_a2", bus_hold, 1);
    chk("s_mex_a2", mex_en, 1);
    chk("s_mex_addr", mex_addr, 64'h0123456780);
    chk("s_mex_attr", mex_attr, 4'h5);
    nxt();
    chk("s_count_a3", dut.count, 0);
    chk("s_mex_a3", mex_en, 0);
    chk("s_hold_a3", bus_hold, 0);

    // Fault: fault_en at ack+1 with the entry address, pop visible at ack+2
    e2 = mk(44'h0ABCDEF0120, 4'h3, 1'b0);
    push_miss(e2);
    nxt();
    chk("f_walk_req", walk_req, 1);
    walk_ack = 1'b1; walk_fault = 1'b1;
    nxt();
    walk_ack = 1'b0; walk_fault = 1'b0;
    chk("f_fault_en", fault_en, 1);
    chk("f_fault_addr", fault_addr, e2.addr);
    chk("f_mex_a1", mex_en, 0);
    chk("f_hold_a1", bus_hold, 0);
    chk("f_count_a1", dut.count, 1);
    nxt();
    chk("f_fault_en_a2", fault_en, 0);
    chk("f_count_a2", dut.count, 0);
    for (int i = 0; i < 4; i++) begin
      chk("f_no_mex", mex_en, 0);
      chk("f_no_walk", walk_req, 0);
      nxt();
    end

    // Fill: full after the 4th, overflow after the 5th, 4 replays in order
    for (int i = 0; i < 5; i++) f[i] = rnd_ent();
    for (int i = 0; i < 5; i++) begin
      push_miss(f[i]);
      chk("fill_full", full, (i >= 3));
      chk("fill_overflow", overflow, (i == 4));
    end
    chk("fill_count", dut.count, 4);
    expq.delete();
    for (int i = 0; i < 4; i++) expq.push_back(f[i]);
    drain(300);
    nxt();
    chk("fill_count_end", dut.count, 0);
    chk("fill_full_end", full, 0);
    chk("fill_ovf_sticky", overflow, 1);
    chk("fill_no_5th", mex_en, 0);

    // Push and pop in the REPLAY cycle
    ea = rnd_ent(); eb = rnd_ent(); ec = rnd_ent();
    push_miss(ea);
    push_miss(eb);
    wait_walk();
    walk_ack = 1'b1;
    nxt();
    walk_ack = 1'b0;
    nxt();
    chk("pp_mex", mex_en, 1);
    chk("pp_mex_addr", mex_addr, ea.addr);
    chk("pp_count_before", dut.count, 2);
    push_miss(ec);
    chk("pp_count_after", dut.count, 2);
    expq.delete();
    expq.push_back(eb); expq.push_back(ec);
    drain(200);
    nxt();
    chk("pp_count_end", dut.count, 0);

    // Flush during WALK, late ack ignored, overflow cleared
    for (int i = 0; i < 5; i++) push_miss(rnd_ent());
    chk("fl_ovf_set", overflow, 1);
    wait_walk();
    except = 1'b1; miss_en = 1'b1; miss_addr = 44'h5A5; 
    nxt();
    except = 1'b0; miss_en = 1'b0; walk_ack = 1'b1;
    chk("fl_count", dut.count, 0);
    chk("fl_walk_req", walk_req, 0);
    chk("fl_overflow", overflow, 0);
    chk("fl_full", full, 0);
    nxt();
    walk_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fl_no_mex", mex_en, 0);
      chk("fl_no_fault", fault_en, 0);
      chk("fl_no_hold", bus_hold, 0);
      chk("fl_no_walk", walk_req, 0);
      nxt();
    end
    // miss_en coincident with except on an empty queue is not enqueued
    except = 1'b1; miss_en = 1'b1;
    nxt();
    except = 1'b0; miss_en = 1'b0;
    chk("fl_coinc_count", dut.count, 0);
    nxt();

    // Reset mid-REPLAY
    push_miss(rnd_ent());
    wait_walk();
    walk_ack = 1'b1;
    nxt();
    walk_ack = 1'b0;
    nxt();
    chk("r_mex_before", mex_en, 1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("rr_walk_req", walk_req, 0);
    chk("rr_bus_hold", bus_hold, 0);
    chk("rr_mex_en", mex_en, 0);
    chk("rr_fault_en", fault_en, 0);
    chk("rr_overflow", overflow, 0);
    chk("rr_full", full, 0);
    chk("rr_mex_addr", mex_addr, 0);
    chk("rr_count", dut.count, 0);
    chk("rr_state", dut.state_q, IDLE);
    nxt();

    // Random traffic against a queue model with an ack-driven event schedule
    mq.delete();
    ovf = 1'b0; sch_hold = '0; sch_mex = '0; sch_fault = '0;
    for (int it = 0; it < 3200; it++) begin
      quiesce = (it >= 3000);
      chk("rnd_full", full, (mq.size() == DEPTH));
      chk("rnd_overflow", overflow, ovf);
      chk("rnd_hold", bus_hold, sch_hold[0]);
      chk("rnd_mex", mex_en, sch_mex[0]);
      chk("rnd_fault", fault_en, sch_fault[0]);
      if (mex_en === 1'b1) begin
        chk("rnd_mex_nonempty", (mq.size() != 0), 1);
        if (mq.size() != 0) begin
          chk("rnd_mex_addr", mex_addr, mq[0].addr);
          chk("rnd_mex_attr", mex_attr, mq[0].attr);
        end
      end
      if (fault_en === 1'b1 && mq.size() != 0) chk("rnd_fault_addr", fault_addr, mq[0].addr);
      if (walk_req === 1'b1) begin
        chk("rnd_walk_nonempty", (mq.size() != 0), 1);
        if (mq.size() != 0) begin
          chk("rnd_walk_addr", walk_addr, mq[0].addr);
          chk("rnd_walk_thread", walk_thread, mq[0].thread);
        end
      end
      sch_hold = sch_hold >> 1; sch_mex = sch_mex >> 1; sch_fault = sch_fault >> 1;

      e1 = rnd_ent();
      miss_en = !quiesce && ($urandom_range(0, 2) == 0);
      miss_addr = e1.addr; miss_attr = e1.attr; miss_thread = e1.thread;
      except = !quiesce && ($urandom_range(0, 59) == 0);
      walk_ack = quiesce ? walk_req : ($urandom_range(0, 2) == 0);
      walk_fault = ($urandom_range(0, 3) == 0);

      if (except) begin
        mq.delete();
        ovf = 1'b0;
        sch_hold = '0; sch_mex = '0; sch_fault = '0;
      end else begin
        push_ok = miss_en && (mq.size() != DEPTH);
        if (miss_en && mq.size() == DEPTH) ovf = 1'b1;
        if ((mex_en === 1'b1 || fault_en === 1'b1) && mq.size() != 0) void'(mq.pop_front());
        if (push_ok) mq.push_back(e1);
        if (walk_ack && walk_req === 1'b1) begin
          if (walk_fault) sch_fault[0] = 1'b1;
          else begin
            sch_hold = 2'b11;
            sch_mex[1] = 1'b1;
          end
        end
      end
      nxt();
    end
    miss_en = 1'b0; except = 1'b0; walk_ack = 1'b0; walk_fault = 1'b0;
    chk("rnd_drained", 64'(mq.size()), 0);
    chk("rnd_count_end", dut.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
